// File: rtl/gf2m_trinomial_reducer.sv
// Sequential top-down reduction of a carry-less product modulo x^M + x^K + 1,
// folding CHUNK high coefficients per cycle into the low part of W.
module gf2m_trinomial_reducer #(
    parameter int M     = 113,
    parameter int K     = 9,
    parameter int PW    = 256,
    parameter int CHUNK = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_rem,
    output logic          out_ovf,
    output logic          busy
);
    localparam int WW = 2 * M - 1;
    localparam int HW = $clog2(WW);

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [WW-1:0]  w_q, w_d, fold_w;
    logic [HW-1:0]  hi_q, hi_d, lo;
    logic           ovf_q, ovf_d, ovf_in;

    generate
        if (PW > WW) begin : g_ovf
            assign ovf_in = |in_prod[PW-1:WW];
        end else begin : g_no_ovf
            assign ovf_in = 1'b0;
        end
    endgenerate

    always_comb begin
        if (hi_q >= HW'(M + CHUNK - 1)) begin
            lo = hi_q - HW'(CHUNK - 1);
        end else begin
            lo = HW'(M);
        end
    end

    // Targets j-M and j-M+K always sit below lo, so reading w_q is safe.
    always_comb begin
        fold_w = w_q;
        for (int j = M; j < WW; j++) begin
            if (HW'(j) >= lo && HW'(j) <= hi_q && w_q[j]) begin
                fold_w[j]         = 1'b0;
                fold_w[j - M]     = fold_w[j - M] ^ 1'b1;
                fold_w[j - M + K] = fold_w[j - M + K] ^ 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        hi_d      = hi_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_rem   = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_d     = in_prod[WW-1:0];
                    ovf_d   = ovf_in;
                    hi_d    = HW'(WW - 1);
                    state_d = FOLD;
                end
            end
            FOLD: begin
                w_d  = fold_w;
                hi_d = lo - HW'(1);
                if (lo == HW'(M)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_rem   = w_q[M-1:0];
                if (out_ready) begin
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Bench for gf2m_trinomial_reducer: bitwise poly-mod model with scoreboard
// plus directed vectors carrying hand-computed remainders.
module tb_gf2m_trinomial_reducer;
    localparam int M  = 113;
    localparam int K  = 9;
    localparam int PW = 256;
    localparam int CH = 16;
    localparam int NF = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_rem;
    logic          out_ovf;
    logic          busy;

    gf2m_trinomial_reducer #(
        .M(M), .K(K), .PW(PW), .CHUNK(CH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rem(out_rem), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    bit     seen   = 1'b0;

    typedef struct {
        logic [M-1:0] rem;
        logic         ovf;
        longint       t;
    } exp_t;
    exp_t q[$];

    // Long division by x^M + x^K + 1, one coefficient at a time.
    function automatic logic [M-1:0] ref_mod(input logic [PW-1:0] p);
        logic [2*M-2:0] w;
        w = p[2*M-2:0];
        for (int j = 2 * M - 2; j >= M; j--) begin
            if (w[j]) begin
                w[j]         = 1'b0;
                w[j - M]     = ~w[j - M];
                w[j - M + K] = ~w[j - M + K];
            end
        end
        return w[M-1:0];
    endfunction

    function automatic logic [PW-1:0] bitp(input int n);
        logic [PW-1:0] r;
        r    = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                q.push_back('{ref_mod(in_prod), |in_prod[PW-1:2*M-1], cyc});
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                seen = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 1'b0);
            end else begin
                chk("sb_rem", out_rem, q[0].rem);
                chk("sb_ovf", out_ovf, q[0].ovf);
                chk("sb_rdy_in_done", in_ready, 1'b0);
                if (!seen) begin
                    chk("sb_latency", cyc - q[0].t, NF + 1);
                    seen = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [PW-1:0] p);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_prod  = p;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            if (!out_valid) chk({nm, "_rdy_lo"}, in_ready, 1'b0);
            n++;
        end
        if (!out_valid) chk({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_vld_drop"}, out_valid, 1'b0);
        chk({nm, "_idle_rdy"}, in_ready, 1'b1);
    endtask

    task automatic run(input logic [PW-1:0] p, input logic [M-1:0] er,
                       input logic eo, input int stall, input string nm);
        send(p);
        wait_valid(nm);
        chk({nm, "_rem"}, out_rem, er);
        chk({nm, "_ovf"}, out_ovf, eo);
        repeat (stall) @(negedge clk);
        handshake(nm);
    endtask

    logic [PW-1:0] rp;
    logic [M-1:0]  top_exp;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        top_exp   = '0;
        top_exp[111] = 1'b1;
        top_exp[16]  = 1'b1;
        top_exp[7]   = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_rem", out_rem, '0);
        chk("rst_ovf", out_ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
        rst_n = 1'b1;

        // pin the model on hand-derived remainders
        chk("model_113", ref_mod(bitp(113)), 113'h201);
        chk("model_224", ref_mod(bitp(224)), top_exp);

        run('0, '0, 1'b0, 0, "zero");
        run(bitp(113), 113'h201, 1'b0, 0, "single");
        run(bitp(224), top_exp, 1'b0, 0, "top");
        run(256'h1234, 113'h1234, 1'b0, 0, "pass");
        run(bitp(225) | bitp(113), 113'h201, 1'b1, 5, "bp_ovf");

        // second product held during DONE must wait for IDLE
        send(bitp(225) | bitp(113));
        wait_valid("hold1");
        in_valid = 1'b1;
        in_prod  = bitp(224);
        repeat (5) begin
            @(negedge clk);
            chk("hold_rdy_lo", in_ready, 1'b0);
            chk("hold_rem", out_rem, 113'h201);
            chk("hold_ovf", out_ovf, 1'b1);
        end
        handshake("hold1");
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid("hold2");
        chk("hold2_rem", out_rem, top_exp);
        chk("hold2_ovf", out_ovf, 1'b0);
        handshake("hold2");

        // asynchronous abort in the third FOLD cycle
        send(bitp(224) | 256'hffff);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_rem", out_rem, '0);
        chk("abort_ovf", out_ovf, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdy", in_ready, 1'b1);
        q.delete();
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(bitp(113), 113'h201, 1'b0, 0, "post_abort");

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) rp[32*k +: 32] = $urandom;
            rp[PW-1:2*M-1] = '0;
            run(rp, ref_mod(rp), 1'b0, i % 3, "rand");
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
